hazard_unit: RTL and testbench

Pipeline control block for the 5-stage MIPS datapath: stalls, flushes and freezes the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC. It sits directly upstream of the EX-stage forwarding logic. Forwarding covers ALU-result hazards only, so this block inserts the load-use bubble that forwarding cannot resolve, and the bubble is what forwarding later sees in EX. It also handles memory wait states, taken-branch flushes, the halt drain sequence and stall statistics.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/hazard_unit_if.sv | 30 +++
 rtl/sat_counter.sv | 16 +
 rtl/hazard_unit.sv | 48 ++++
 tb/tb_hazard_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the 5-stage MIPS pipeline
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} hazard_state_t;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: signal bundle between the hazard unit and the pipeline latches
interface hazard_unit_if #(parameter int CNT_W = 32) (input logic CLK, input logic nRST);
    import cpu_types_pkg::*;
    logic             ihit, dhit;
    regbits_t         rs_id, rt_id;
    logic             use_rs_id, use_rt_id;
    logic             ex_memread;
    regbits_t         ex_wsel;
    logic             mem_dren, mem_dwen;
    logic             br_taken_mem, halt_mem;
    logic             pc_en;
    logic             en_ifid, en_idex, en_exmem, en_memwb;
    logic             flush_ifid, flush_idex, flush_exmem;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, dwait_cnt, flush_cnt;
    modport hu (
        input  CLK, nRST, ihit, dhit, rs_id, rt_id, use_rs_id, use_rt_id,
               ex_memread, ex_wsel, mem_dren, mem_dwen, br_taken_mem, halt_mem,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, halted,
               stall_cnt, dwait_cnt, flush_cnt
    );
    modport tb (
        input  CLK, nRST, pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, halted,
               stall_cnt, dwait_cnt, flush_cnt,
        output ihit, dhit, rs_id, rt_id, use_rs_id, use_rt_id,
               ex_memread, ex_wsel, mem_dren, mem_dwen, br_taken_mem, halt_mem
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its maximum value
module sat_counter #(parameter int W = 32) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            r_count <= '0;
        else
            r_count <= clear ? '0 : (inc && r_count != '1) ? r_count + 1'b1 : r_count;
    assign count = r_count;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/freeze control, halt drain and stall statistics
module hazard_unit import cpu_types_pkg::*; #(parameter int CNT_W = 32) (
    hazard_unit_if.hu hif
);
    hazard_state_t r_state, w_next;
    logic          r_halted;
    logic          w_run, w_dwait, w_lu, w_go, w_br;
    assign w_dwait = (hif.mem_dren | hif.mem_dwen) & ~hif.dhit;
    assign w_lu    = hif.ex_memread & (hif.ex_wsel != '0) &
                     ((hif.use_rs_id & (hif.rs_id == hif.ex_wsel)) |
                      (hif.use_rt_id & (hif.rt_id == hif.ex_wsel)));
    assign w_run   = r_state == RUN;
    // w_go: RUN with neither a memory wait nor a halt, i.e. the front end may move
    assign w_go    = w_run & ~w_dwait & ~hif.halt_mem;
    assign w_br    = w_go & hif.br_taken_mem;
    assign hif.pc_en       = w_br | (w_go & ~w_lu & hif.ihit);
    assign hif.en_ifid     = w_br | (w_go & ~w_lu);
    assign hif.en_idex     = w_go;
    assign hif.en_exmem    = w_go;
    assign hif.en_memwb    = w_run & ~w_dwait;
    assign hif.flush_ifid  = w_br | (w_go & ~w_lu & ~hif.ihit);
    assign hif.flush_idex  = w_br | (w_go & w_lu);
    assign hif.flush_exmem = w_br;
    assign hif.halted      = r_halted;
    always_comb
        w_next = (r_state == RUN) ? ((~w_dwait & hif.halt_mem) ? DRAIN : RUN) : HALTED;
    always_ff @(posedge hif.CLK or negedge hif.nRST)
        if (!hif.nRST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= w_next == HALTED;
        end
    sat_counter #(.W(CNT_W)) u_stall (
        .CLK(hif.CLK), .nRST(hif.nRST),
        .inc(w_go & ~hif.br_taken_mem & (w_lu | ~hif.ihit)),
        .clear(1'b0), .count(hif.stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_dwait (
        .CLK(hif.CLK), .nRST(hif.nRST),
        .inc(w_run & w_dwait), .clear(1'b0), .count(hif.dwait_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush (
        .CLK(hif.CLK), .nRST(hif.nRST),
        .inc(w_br), .clear(1'b0), .count(hif.flush_cnt)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed + random checks of hazard_unit against a rule-table model
module tb_hazard_unit;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;
    hazard_unit_if #(.CNT_W(CW)) hif (.CLK(CLK), .nRST(nRST));
    hazard_unit #(.CNT_W(CW)) dut (.hif(hif));
    int total = 0;
    int bad = 0;
    int m_state = 0;
    int m_stall = 0, m_dwait = 0, m_flush = 0;
    bit m_halted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_lu();
        bit hit = 0;
        logic [4:0] srcs [2];
        bit uses [2];
        srcs[0] = hif.rs_id; srcs[1] = hif.rt_id;
        uses[0] = hif.use_rs_id; uses[1] = hif.use_rt_id;
        for (int i = 0; i < 2; i++)
            if (uses[i] && srcs[i] == hif.ex_wsel) hit = 1;
        return hif.ex_memread && hif.ex_wsel != 0 && hit;
    endfunction

    function automatic bit m_dw();
        return (hif.mem_dren || hif.mem_dwen) && !hif.dhit;
    endfunction

    // 0 freeze, 1 halt, 2 branch, 3 load-use, 4 fetch miss, 5 normal, 6 not running
    function automatic int m_rule();
        if (m_state != 0) return 6;
        if (m_dw()) return 0;
        if (hif.halt_mem) return 1;
        if (hif.br_taken_mem) return 2;
        if (m_lu()) return 3;
        if (!hif.ihit) return 4;
        return 5;
    endfunction

    // {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem}
    function automatic logic [7:0] m_ctrl(input int r);
        logic [7:0] tbl [7];
        tbl[0] = 8'b0000_0000;
        tbl[1] = 8'b0000_1000;
        tbl[2] = 8'b1111_1111;
        tbl[3] = 8'b0011_1010;
        tbl[4] = 8'b0111_1100;
        tbl[5] = 8'b1111_1000;
        tbl[6] = 8'b0000_0000;
        return tbl[r];
    endfunction

    function automatic int sat(input int v, input bit inc);
        return (inc && v < MAX) ? v + 1 : v;
    endfunction

    task automatic check_now(input string tag);
        logic [7:0] obs;
        obs = {hif.pc_en, hif.en_ifid, hif.en_idex, hif.en_exmem, hif.en_memwb,
               hif.flush_ifid, hif.flush_idex, hif.flush_exmem};
        chk({tag, ".ctrl"}, 32'(obs), 32'(m_ctrl(m_rule())));
        chk({tag, ".halted"}, 32'(hif.halted), 32'(m_halted));
        chk({tag, ".stall_cnt"}, 32'(hif.stall_cnt), 32'(m_stall));
        chk({tag, ".dwait_cnt"}, 32'(hif.dwait_cnt), 32'(m_dwait));
        chk({tag, ".flush_cnt"}, 32'(hif.flush_cnt), 32'(m_flush));
    endtask

    task automatic cyc(input string tag);
        int r;
        #1;
        check_now(tag);
        r = m_rule();
        @(posedge CLK);
        m_dwait = sat(m_dwait, r == 0);
        m_flush = sat(m_flush, r == 2);
        m_stall = sat(m_stall, r == 3 || r == 4);
        m_state = (m_state == 0) ? (r == 1 ? 1 : 0) : 2;
        m_halted = m_state == 2;
        #1;
    endtask

    task automatic idle();
        hif.ihit = 1; hif.dhit = 1;
        hif.rs_id = 0; hif.rt_id = 0; hif.use_rs_id = 0; hif.use_rt_id = 0;
        hif.ex_memread = 0; hif.ex_wsel = 0;
        hif.mem_dren = 0; hif.mem_dwen = 0;
        hif.br_taken_mem = 0; hif.halt_mem = 0;
    endtask

    task automatic rand_in(input bit allow_halt);
        hif.ihit = $urandom_range(0, 3) != 0;
        hif.dhit = $urandom_range(0, 2) != 0;
        hif.rs_id = 5'($urandom_range(0, 3));
        hif.rt_id = 5'($urandom_range(0, 3));
        hif.use_rs_id = 1'($urandom);
        hif.use_rt_id = 1'($urandom);
        hif.ex_memread = 1'($urandom);
        hif.ex_wsel = 5'($urandom_range(0, 3));
        hif.mem_dren = $urandom_range(0, 3) == 0;
        hif.mem_dwen = $urandom_range(0, 5) == 0;
        hif.br_taken_mem = $urandom_range(0, 4) == 0;
        hif.halt_mem = allow_halt && $urandom_range(0, 40) == 0;
    endtask

    task automatic do_reset(input string tag);
        nRST = 0;
        m_state = 0; m_stall = 0; m_dwait = 0; m_flush = 0; m_halted = 0;
        #1;
        check_now(tag);
        idle();
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        hif.ex_memread = 1; hif.ex_wsel = 7; hif.rt_id = 7; hif.use_rt_id = 1;
        #1;
        check_now("reset_lu");
        idle();
        #1;
        check_now("reset_idle");
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
        cyc("normal");
        hif.ex_memread = 1; hif.ex_wsel = 2; hif.rs_id = 2; hif.use_rs_id = 1;
        cyc("lu_stall");
        hif.ex_memread = 0;
        cyc("lu_after");
        hif.ex_memread = 1; hif.ex_wsel = 0; hif.rs_id = 0;
        cyc("lu_wsel0");
        hif.ex_wsel = 2; hif.rs_id = 2; hif.rt_id = 2; hif.use_rs_id = 0; hif.use_rt_id = 0;
        cyc("lu_unused");
        hif.use_rt_id = 1; hif.br_taken_mem = 1; hif.mem_dren = 1; hif.dhit = 0;
        for (int i = 0; i < 3; i++) cyc("dwait_mask");
        hif.dhit = 1;
        cyc("br_after_wait");
        idle();
        hif.ihit = 0;
        cyc("imiss0");
        cyc("imiss1");
        hif.ihit = 1;
        hif.mem_dwen = 1; hif.dhit = 0;
        cyc("dwen_wait");
        idle();
        hif.halt_mem = 1; hif.mem_dren = 1; hif.dhit = 0;
        cyc("halt_masked");
        idle();
        for (int i = 0; i < 300; i++) begin
            rand_in(0);
            cyc("rand");
        end
        do_reset("reset_mid");
        hif.ihit = 0;
        for (int i = 0; i < MAX + 3; i++) cyc("stall_sat");
        idle();
        hif.br_taken_mem = 1;
        for (int i = 0; i < MAX + 3; i++) cyc("flush_sat");
        idle();
        hif.halt_mem = 1; hif.br_taken_mem = 1; hif.ex_memread = 1; hif.ex_wsel = 3;
        hif.rs_id = 3; hif.use_rs_id = 1; hif.ihit = 0;
        cyc("halt");
        idle();
        hif.br_taken_mem = 1;
        cyc("drain");
        for (int i = 0; i < 8; i++) begin
            rand_in(1);
            cyc("halted_rand");
        end
        @(negedge CLK);
        do_reset("reset_halted");
        cyc("post_reset");
        for (int i = 0; i < 200; i++) begin
            rand_in(1);
            cyc("rand2");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
